// File: rtl/sprite_program_sequencer_if.sv
// Command channel from the game logic into the sprite program sequencer.
// The master drives the command; the slave (the sequencer) returns ready.
interface sprite_program_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_id;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [15:0] cmd_addr;

    modport master (output cmd_valid, output cmd_id, output cmd_x, output cmd_y,
                    output cmd_addr, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_id, input cmd_x, input cmd_y,
                    input cmd_addr, output cmd_ready);
endinterface

// File: rtl/sprite_program_sequencer.sv
// Queues sprite reprogramming commands and replays them onto the shared sprite
// set bus during vertical blank; also sequences the global chain clear.
module sprite_program_sequencer #(
    parameter int unsigned NUM_SPRITES   = 64,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      vblank,
    input  logic                      clear_req,
    sprite_program_sequencer_if.slave cmd,
    output logic [5:0]                requested_sprite_id,
    output logic [7:0]                setx,
    output logic [7:0]                sety,
    output logic [15:0]               set_address,
    output logic                      program_active,
    output logic                      clear,
    output logic                      busy,
    output logic                      err_bad_id,
    output logic [7:0]                prog_count
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STROBE_CYCLES) + 1;
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STROBE_ONE  = SW'(1);
    localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CLR    = 3'd4
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [37:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          clear_pending_r;
    logic [SW-1:0] strobe_cnt_r;
    logic [5:0]    id_r;
    logic [7:0]    x_r;
    logic [7:0]    y_r;
    logic [15:0]   addr_r;
    logic          program_active_r;
    logic          clear_r;
    logic          err_bad_id_r;
    logic [7:0]    prog_count_r;

    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          cmd_ready_s;
    logic          push_s;
    logic          pop_s;
    logic [37:0]   head_s;
    logic          head_ok_s;
    logic          strobe_done_s;
    logic          program_active_nxt_s;
    logic          clear_nxt_s;

    assign fifo_empty_s  = (count_r == {CW{1'b0}});
    assign fifo_full_s   = (count_r == CNT_FULL);
    assign cmd_ready_s   = !fifo_full_s && !clear_pending_r && (state_r != ST_CLR);
    assign push_s        = cmd.cmd_valid && cmd_ready_s;
    assign pop_s         = (state_r == ST_IDLE) && !clear_pending_r && !fifo_empty_s && vblank;
    assign head_s        = mem_r[rd_ptr_r];
    assign head_ok_s     = ({26'd0, head_s[37:32]} < NUM_SPRITES);
    assign strobe_done_s = (state_r == ST_STROBE) && (strobe_cnt_r == STROBE_LAST);

    // Command storage; contents need no reset because occupancy is tracked by count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd.cmd_id, cmd.cmd_x, cmd.cmd_y, cmd.cmd_addr};
        end
    end

    // Queue pointers and occupancy; a chain clear flushes the queue.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (state_r == ST_CLR) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Pending clear; a request seen while already clearing is absorbed.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            clear_pending_r <= 1'b0;
        end else if (state_r == ST_CLR) begin
            clear_pending_r <= 1'b0;
        end else if (clear_req) begin
            clear_pending_r <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a pending clear only takes over from IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_pending_r) begin
                    next_state_s = ST_CLR;
                end else if (pop_s && head_ok_s) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP:  next_state_s = ST_STROBE;
            ST_STROBE: begin
                if (strobe_done_s) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_STROBE;
                end
            end
            ST_HOLD:   next_state_s = ST_IDLE;
            ST_CLR:    next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode, computed for the next state so the strobes come out of flops.
    always_comb begin
        program_active_nxt_s = 1'b0;
        clear_nxt_s          = 1'b0;
        case (next_state_s)
            ST_STROBE: program_active_nxt_s = 1'b1;
            ST_CLR:    clear_nxt_s          = 1'b1;
            default: begin
                program_active_nxt_s = 1'b0;
                clear_nxt_s          = 1'b0;
            end
        endcase
    end

    // Registered strobes and strobe-length counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            program_active_r <= 1'b0;
            clear_r          <= 1'b0;
            strobe_cnt_r     <= {SW{1'b0}};
        end else begin
            program_active_r <= program_active_nxt_s;
            clear_r          <= clear_nxt_s;
            strobe_cnt_r     <= (state_r == ST_STROBE) ? strobe_cnt_r + STROBE_ONE : {SW{1'b0}};
        end
    end

    // Set-bus registers; they hold their last value across IDLE and CLR.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            id_r   <= 6'd0;
            x_r    <= 8'd0;
            y_r    <= 8'd0;
            addr_r <= 16'd0;
        end else if (pop_s && head_ok_s) begin
            {id_r, x_r, y_r, addr_r} <= head_s;
        end
    end

    // Status: sticky bad-id flag and completed-programming counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            err_bad_id_r <= 1'b0;
            prog_count_r <= 8'd0;
        end else if (state_r == ST_CLR) begin
            err_bad_id_r <= 1'b0;
            prog_count_r <= 8'd0;
        end else begin
            if (pop_s && !head_ok_s) err_bad_id_r <= 1'b1;
            if (strobe_done_s)       prog_count_r <= prog_count_r + 8'd1;
        end
    end

    assign cmd.cmd_ready         = cmd_ready_s;
    assign requested_sprite_id   = id_r;
    assign setx                  = x_r;
    assign sety                  = y_r;
    assign set_address           = addr_r;
    assign program_active        = program_active_r;
    assign clear                 = clear_r;
    assign busy                  = (state_r != ST_IDLE) || !fifo_empty_s;
    assign err_bad_id            = err_bad_id_r;
    assign prog_count            = prog_count_r;
endmodule

// File: tb/tb_sprite_program_sequencer.sv
// Directed bench for sprite_program_sequencer with NUM_SPRITES=32, FIFO_DEPTH=4,
// STROBE_CYCLES=2; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sprite_program_sequencer;
    logic        clk;
    logic        clear_n;
    logic        vblank;
    logic        clear_req;
    logic [5:0]  requested_sprite_id;
    logic [7:0]  setx;
    logic [7:0]  sety;
    logic [15:0] set_address;
    logic        program_active;
    logic        clear;
    logic        busy;
    logic        err_bad_id;
    logic [7:0]  prog_count;
    logic [37:0] bus_s;
    int          checks;
    int          failures;

    sprite_program_sequencer_if cmd_if ();

    sprite_program_sequencer #(
        .NUM_SPRITES(32), .FIFO_DEPTH(4), .STROBE_CYCLES(2)
    ) dut (
        .clk(clk), .clear_n(clear_n), .vblank(vblank), .clear_req(clear_req), .cmd(cmd_if),
        .requested_sprite_id(requested_sprite_id), .setx(setx), .sety(sety),
        .set_address(set_address), .program_active(program_active), .clear(clear),
        .busy(busy), .err_bad_id(err_bad_id), .prog_count(prog_count)
    );

    assign bus_s = {requested_sprite_id, setx, sety, set_address};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] pack(input logic [5:0] id, input logic [7:0] x,
                                         input logic [7:0] y, input logic [15:0] a);
        return {id, x, y, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [37:0] c);
        cmd_if.cmd_valid = 1'b1;
        {cmd_if.cmd_id, cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_addr} = c;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; vblank = 1'b0; clear_req = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        {cmd_if.cmd_id, cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_addr} = 38'd0;
        #12;
        checks++; if ({program_active, clear, err_bad_id, busy} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b want 0000", {program_active, clear, err_bad_id, busy}); end
        checks++; if (bus_s !== 38'd0) begin
            failures++; $display("FAIL reset_bus: got %h want 0", bus_s); end
        checks++; if (prog_count !== 8'd0) begin
            failures++; $display("FAIL reset_prog_count: got %0d want 0", prog_count); end
        #11; clear_n = 1'b1;
        tick();
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_single();
        logic [37:0] exp_b;
        exp_b = pack(6'd3, 8'd10, 8'd20, 16'h0100);
        vblank = 1'b1;
        push(exp_b);
        tick();
        checks++; if ({program_active, busy, bus_s} !== {2'b01, exp_b}) begin
            failures++; $display("FAIL single_setup: got pa=%b busy=%b bus=%h want pa=0 busy=1 bus=%h", program_active, busy, bus_s, exp_b); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if ({program_active, bus_s} !== {1'b1, exp_b}) begin
                failures++; $display("FAIL single_strobe%0d: got pa=%b bus=%h want pa=1 bus=%h", c, program_active, bus_s, exp_b); end
        end
        tick();
        checks++; if ({program_active, bus_s, prog_count} !== {1'b0, exp_b, 8'd1}) begin
            failures++; $display("FAIL single_hold: got pa=%b bus=%h cnt=%0d want pa=0 bus=%h cnt=1", program_active, bus_s, prog_count, exp_b); end
        tick();
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_queue_fill();
        logic [37:0] exp_q [4];
        int          rise_cyc [8];
        logic [37:0] rise_bus [8];
        logic        busy_h [32];
        int          n;
        int          early;
        logic        prev;
        exp_q[0] = pack(6'd1, 8'd11, 8'd21, 16'h1001);
        exp_q[1] = pack(6'd2, 8'd12, 8'd22, 16'h2002);
        exp_q[2] = pack(6'd5, 8'd13, 8'd23, 16'h3003);
        exp_q[3] = pack(6'd31, 8'd14, 8'd24, 16'h4004);
        vblank = 1'b0;
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        checks++; if ({cmd_if.cmd_ready, busy} !== 2'b01) begin
            failures++; $display("FAIL queue_full: got ready=%b busy=%b want ready=0 busy=1", cmd_if.cmd_ready, busy); end
        early = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (program_active !== 1'b0) early++;
        end
        checks++; if (early != 0) begin
            failures++; $display("FAIL queue_no_vblank_strobe: got %0d strobe cycles want 0", early); end
        vblank = 1'b1; n = 0; prev = program_active;
        for (int c = 0; c < 30; c++) begin
            tick();
            busy_h[c] = busy;
            if (program_active && !prev && n < 8) begin
                rise_cyc[n] = c; rise_bus[n] = bus_s; n++;
            end
            prev = program_active;
        end
        checks++; if (n != 4) begin
            failures++; $display("FAIL queue_rises: got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++; if (rise_bus[i] !== exp_q[i]) begin
                failures++; $display("FAIL queue_order%0d: got %h want %h", i, rise_bus[i], exp_q[i]); end
            checks++; if (rise_cyc[i] != 1 + 5 * i) begin
                failures++; $display("FAIL queue_spacing%0d: got cycle %0d want %0d", i, rise_cyc[i], 1 + 5 * i); end
        end
        checks++; if ({busy_h[18], busy_h[19]} !== 2'b10) begin
            failures++; $display("FAIL queue_busy_fall: got %b%b want 10", busy_h[18], busy_h[19]); end
        checks++; if (prog_count !== 8'd5) begin
            failures++; $display("FAIL queue_prog_count: got %0d want 5", prog_count); end
    endtask

    task automatic test_bad_id();
        logic [37:0] exp_b;
        logic [37:0] seen;
        int          n;
        logic        prev;
        exp_b = pack(6'd7, 8'd70, 8'd80, 16'h7777);
        vblank = 1'b1;
        push(pack(6'd63, 8'd1, 8'd2, 16'hdead));
        push(exp_b);
        n = 0; prev = program_active; seen = 38'd0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (program_active && !prev) begin
                n++; seen = bus_s;
            end
            prev = program_active;
        end
        checks++; if (n != 1) begin
            failures++; $display("FAIL bad_id_rises: got %0d want 1", n); end
        checks++; if (seen !== exp_b) begin
            failures++; $display("FAIL bad_id_next_bus: got %h want %h", seen, exp_b); end
        checks++; if ({err_bad_id, prog_count} !== {1'b1, 8'd6}) begin
            failures++; $display("FAIL bad_id_status: got err=%b cnt=%0d want err=1 cnt=6", err_bad_id, prog_count); end
    endtask

    task automatic test_clear_mid();
        logic [37:0] exp_a;
        int          clr_n;
        int          clr_first;
        int          rises;
        int          overlap;
        logic        prev;
        exp_a = pack(6'd10, 8'd100, 8'd110, 16'haaaa);
        vblank = 1'b1;
        push(exp_a);
        push(pack(6'd11, 8'd101, 8'd111, 16'hbbbb));
        push(pack(6'd12, 8'd102, 8'd112, 16'hcccc));
        for (int i = 0; i < 10 && program_active !== 1'b1; i++) tick();
        checks++; if (program_active !== 1'b1) begin
            failures++; $display("FAIL clear_mid_wait_strobe: got %b want 1", program_active); end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        checks++; if (program_active !== 1'b1) begin
            failures++; $display("FAIL clear_mid_strobe_completes: got %b want 1", program_active); end
        clr_n = 0; clr_first = -1; rises = 0; overlap = 0; prev = program_active;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (clear) begin
                clr_n++;
                if (clr_first < 0) clr_first = c;
            end
            if (program_active && !prev) rises++;
            if (program_active && clear) overlap++;
            prev = program_active;
        end
        checks++; if (clr_n != 1 || clr_first != 2) begin
            failures++; $display("FAIL clear_mid_pulse: got %0d cycles at %0d want 1 at 2", clr_n, clr_first); end
        checks++; if (rises != 0 || overlap != 0) begin
            failures++; $display("FAIL clear_mid_flushed: got rises=%0d overlap=%0d want 0/0", rises, overlap); end
        checks++; if ({prog_count, err_bad_id, busy, cmd_if.cmd_ready} !== {8'd0, 3'b001}) begin
            failures++; $display("FAIL clear_mid_status: got cnt=%0d err=%b busy=%b ready=%b want 0 0 0 1", prog_count, err_bad_id, busy, cmd_if.cmd_ready); end
        checks++; if (bus_s !== exp_a) begin
            failures++; $display("FAIL clear_mid_bus_kept: got %h want %h", bus_s, exp_a); end
    endtask

    task automatic test_clear_same_cycle();
        int clr_n;
        int pa_n;
        vblank = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        {cmd_if.cmd_id, cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_addr} = pack(6'd5, 8'd55, 8'd66, 16'h5555);
        clear_req = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0; clear_req = 1'b0;
        checks++; if ({busy, cmd_if.cmd_ready} !== 2'b10) begin
            failures++; $display("FAIL same_cycle_accept: got busy=%b ready=%b want busy=1 ready=0", busy, cmd_if.cmd_ready); end
        clr_n = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            clear_req = clear;
            if (clear) clr_n++;
        end
        clear_req = 1'b0;
        vblank = 1'b1; pa_n = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (program_active) pa_n++;
        end
        checks++; if (clr_n != 1) begin
            failures++; $display("FAIL same_cycle_one_pulse: got %0d want 1", clr_n); end
        checks++; if (pa_n != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL same_cycle_flushed: got strobes=%0d busy=%b want 0 0", pa_n, busy); end
    endtask

    task automatic test_vblank_drop();
        logic [37:0] exp_a;
        logic [37:0] exp_b;
        logic [37:0] seen;
        int          hi;
        int          n;
        logic        prev;
        exp_a = pack(6'd20, 8'd1, 8'd2, 16'h0a0a);
        exp_b = pack(6'd21, 8'd3, 8'd4, 16'h0b0b);
        vblank = 1'b1;
        push(exp_a);
        push(exp_b);
        for (int i = 0; i < 10 && program_active !== 1'b1; i++) tick();
        checks++; if (program_active !== 1'b1) begin
            failures++; $display("FAIL vdrop_wait_strobe: got %b want 1", program_active); end
        vblank = 1'b0; hi = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (program_active) hi++;
        end
        checks++; if (hi != 2) begin
            failures++; $display("FAIL vdrop_strobe_len: got %0d want 2", hi); end
        checks++; if ({busy, bus_s} !== {1'b1, exp_a}) begin
            failures++; $display("FAIL vdrop_waiting: got busy=%b bus=%h want busy=1 bus=%h", busy, bus_s, exp_a); end
        vblank = 1'b1; n = 0; prev = program_active; seen = 38'd0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (program_active && !prev) begin
                n++; seen = bus_s;
            end
            prev = program_active;
        end
        checks++; if (n != 1 || seen !== exp_b) begin
            failures++; $display("FAIL vdrop_resume: got %0d rises bus=%h want 1 bus=%h", n, seen, exp_b); end
        checks++; if (prog_count !== 8'd2) begin
            failures++; $display("FAIL vdrop_prog_count: got %0d want 2", prog_count); end
    endtask

    task automatic test_async_reset();
        int pa_n;
        vblank = 1'b1;
        push(pack(6'd30, 8'd9, 8'd8, 16'h1234));
        push(pack(6'd31, 8'd7, 8'd6, 16'h5678));
        for (int i = 0; i < 10 && program_active !== 1'b1; i++) tick();
        checks++; if (program_active !== 1'b1) begin
            failures++; $display("FAIL areset_wait_strobe: got %b want 1", program_active); end
        #2; clear_n = 1'b0;
        #1;
        checks++; if ({program_active, clear, busy, bus_s} !== 41'd0) begin
            failures++; $display("FAIL areset_immediate: got pa=%b clr=%b busy=%b bus=%h want all 0", program_active, clear, busy, bus_s); end
        #3; clear_n = 1'b1;
        tick();
        checks++; if ({cmd_if.cmd_ready, busy, prog_count} !== {2'b10, 8'd0}) begin
            failures++; $display("FAIL areset_release: got ready=%b busy=%b cnt=%0d want 1 0 0", cmd_if.cmd_ready, busy, prog_count); end
        pa_n = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (program_active) pa_n++;
        end
        checks++; if (pa_n != 0) begin
            failures++; $display("FAIL areset_fifo_empty: got %0d strobe cycles want 0", pa_n); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_queue_fill();
        test_bad_id();
        test_clear_mid();
        test_clear_same_cycle();
        test_vblank_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
